// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one 32-bit ALU; round-robin on contention, or port 0 always wins with ALU_ARBITER_FIXED_PRIO_EN.
// Accept at edge k, result held from edge k+1 until the owner's rsp ready; req ready stays low while busy (no queuing).
module alu_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [DATA_W-1:0] req0_dato1_i,
  input  logic [DATA_W-1:0] req0_dato2_i,
  input  logic [2:0]        req0_op_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [DATA_W-1:0] req1_dato1_i,
  input  logic [DATA_W-1:0] req1_dato2_i,
  input  logic [2:0]        req1_op_i,
  output logic [DATA_W-1:0] alu_dato1_o,
  output logic [DATA_W-1:0] alu_dato2_o,
  output logic [2:0]        alu_alucontrol_o,
  input  logic [DATA_W-1:0] alu_aluout_i,
  input  logic              alu_zero_i,
  input  logic              alu_signo_i,
  output logic              rsp0_valid_o,
  input  logic              rsp0_ready_i,
  output logic              rsp1_valid_o,
  input  logic              rsp1_ready_i,
  output logic [DATA_W-1:0] rsp_aluout_o,
  output logic              rsp_zero_o,
  output logic              rsp_signo_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  logic   owner;
  logic   grant;
  logic   accept;
  logic   rsp_hs;
`ifndef ALU_ARBITER_FIXED_PRIO_EN
  logic   last_grant;
`endif

  // grant names the winning port; it only matters while a valid is present
  always_comb begin
    grant = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
`ifdef ALU_ARBITER_FIXED_PRIO_EN
      grant = 1'b0;
`else
      grant = ~last_grant;
`endif
    end else if (req1_valid_i) begin
      grant = 1'b1;
    end
  end

  assign req0_ready_o = !rst_i && (state == IDLE) && req0_valid_i && !grant;
  assign req1_ready_o = !rst_i && (state == IDLE) && req1_valid_i && grant;
  assign accept       = req0_ready_o || req1_ready_o;

  // only the owner's ready can retire the response
  assign rsp_hs = owner ? rsp1_ready_i : rsp0_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= IDLE;
      owner            <= 1'b0;
`ifndef ALU_ARBITER_FIXED_PRIO_EN
      last_grant       <= 1'b1;
`endif
      alu_dato1_o      <= '0;
      alu_dato2_o      <= '0;
      alu_alucontrol_o <= 3'b000;
      rsp_aluout_o     <= '0;
      rsp_zero_o       <= 1'b0;
      rsp_signo_o      <= 1'b0;
      rsp0_valid_o     <= 1'b0;
      rsp1_valid_o     <= 1'b0;
      busy_o           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner            <= grant;
`ifndef ALU_ARBITER_FIXED_PRIO_EN
            last_grant       <= grant;
`endif
            alu_dato1_o      <= grant ? req1_dato1_i : req0_dato1_i;
            alu_dato2_o      <= grant ? req1_dato2_i : req0_dato2_i;
            alu_alucontrol_o <= grant ? req1_op_i : req0_op_i;
            busy_o           <= 1'b1;
            state            <= EXEC;
          end
        end
        EXEC: begin
          rsp_aluout_o <= alu_aluout_i;
          rsp_zero_o   <= alu_zero_i;
          rsp_signo_o  <= alu_signo_i;
          rsp0_valid_o <= !owner;
          rsp1_valid_o <= owner;
          state        <= RESP;
        end
        RESP: begin
          if (rsp_hs) begin
            rsp0_valid_o <= 1'b0;
            rsp1_valid_o <= 1'b0;
            busy_o       <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
